downcount_timer: RTL and testbench

- Loadable down-counter/timer; the counting-down counterpart of the team's free-running up-counter.
- Accepts a start value over a valid/ready load handshake and counts to zero.
- Emits a one-cycle done pulse at terminal count, in one-shot or auto-reload mode.
- Sits beside the up-counters as the timeout/period generator for control FSMs.

---
 rtl/downcount_timer_pkg.sv | 19 +
 rtl/downcount_timer_if.sv | 32 +++
 rtl/downcount_timer_tick_prescaler.sv | 47 ++++
 rtl/downcount_timer.sv | 139 +++++++++++++
 tb/tb_downcount_timer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/downcount_timer_pkg.sv
// downcount_timer_pkg
//   Shared types and defaults for the downcount_timer block.
//   - state_t              : controller state (IDLE, RUN)
//   - DEFAULT_WIDTH        : default counter width
//   - DEFAULT_PRESCALE_DIV : default cycles per decrement when the prescaler
//                            is compiled in (DOWNCOUNT_PRESCALE_EN)
//   - DEFAULT_MAX_COUNT    : largest start value at DEFAULT_WIDTH
package downcount_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH        = 4;
  localparam int unsigned DEFAULT_PRESCALE_DIV = 4;
  localparam int unsigned DEFAULT_MAX_COUNT    = (1 << DEFAULT_WIDTH) - 1;

endpackage

// File: rtl/downcount_timer_if.sv
// downcount_timer_if
//   Load handshake bundle for downcount_timer.
//   Signals:
//     load_valid  : start request (master -> slave)
//     load_ready  : slave can accept a load (slave -> master)
//     load_value  : start count, WIDTH bits (master -> slave)
//     auto_reload : run mode, 1 = reload after terminal (master -> slave)
//   Modports: master (requester), slave (timer).
interface downcount_timer_if #(
  parameter int unsigned WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;

  modport master (
    output load_valid,
    output load_value,
    output auto_reload,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  auto_reload,
    output load_ready
  );

endinterface

// File: rtl/downcount_timer_tick_prescaler.sv
// tick_prescaler
//   Modulo-PRESCALE_DIV cycle counter producing one tick per PRESCALE_DIV
//   un-held cycles. Used by downcount_timer only when DOWNCOUNT_PRESCALE_EN
//   is defined.
//   Ports:
//     clk    : clock, all state on posedge
//     rst    : synchronous active-high reset
//     clr_i  : synchronous clear of the phase counter
//     hold_i : freezes the phase counter and suppresses tick
//     tick_o : high in the cycle the counter sits at its terminal value
module tick_prescaler #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_term;

  assign at_term = (cnt_q == TERM);
  assign tick_o  = at_term && !hold_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i) begin
      cnt_d = at_term ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/downcount_timer.sv
// downcount_timer
//   Loadable down-counter / timer. A start value is accepted over a
//   valid/ready handshake; the block counts to zero and emits a one-cycle
//   done pulse at terminal count, either once (one-shot) or repeatedly
//   (auto-reload). Optional prescaler: define DOWNCOUNT_PRESCALE_EN to
//   decrement once per PRESCALE_DIV unpaused RUN cycles.
//   Ports:
//     clk     : clock, all state on posedge
//     rst     : synchronous active-high reset
//     load_if : load handshake (slave modport of downcount_timer_if)
//     pause   : freezes counting (and prescaler) while high
//     abort   : stops a run without done; blocks a load in IDLE
//     count   : current count, registered
//     busy    : high while running
//     done    : one-cycle registered terminal pulse
module downcount_timer
  import downcount_timer_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  downcount_timer_if.slave      load_if,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  if (PRESCALE_DIV < 2) begin : g_bad_div
    $error("downcount_timer: PRESCALE_DIV must be at least 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             ar_q, ar_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready;
  logic             tick;

  assign load_ready         = (state_q == IDLE) && !abort;
  assign load_if.load_ready = load_ready;

`ifdef DOWNCOUNT_PRESCALE_EN
  // Clearing for the whole of IDLE covers both the handshake and the abort
  // that leads back to IDLE; a reload needs no clear because the prescaler
  // has just wrapped to zero on the tick that caused it.
  logic presc_clr;
  assign presc_clr = (state_q == IDLE) || abort;

  tick_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr_i (presc_clr),
    .hold_i(pause),
    .tick_o(tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    ar_d     = ar_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_if.load_valid && load_ready) begin
          count_d  = load_if.load_value;
          reload_d = load_if.load_value;
          ar_d     = load_if.auto_reload;
          if (load_if.load_value != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end else if (tick && !pause) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (ar_q) begin
            count_d = reload_q;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
            count_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      ar_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      ar_q     <= ar_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_downcount_timer.sv
// tb_downcount_timer
//   Directed self-checking bench for downcount_timer (default build, one
//   decrement per cycle). Each step pushes the outputs expected after the
//   next clock edge into a scoreboard queue; the entry is popped and
//   compared 1 time unit after that edge.
module tb_downcount_timer;

  localparam int unsigned W = 4;

  typedef struct {
    string        tag;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         ready;
  } exp_t;

  logic clk;
  logic rst;
  logic pause;
  logic abort;
  logic [W-1:0] count;
  logic busy;
  logic done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sb[$];

  downcount_timer_if #(.WIDTH(W)) ld ();

  downcount_timer #(
    .WIDTH(W),
    .PRESCALE_DIV(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load_if(ld.slave),
    .pause  (pause),
    .abort  (abort),
    .count  (count),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] c,
                            input logic b, input logic d, input logic r);
    exp_t e;
    e.tag = tag; e.count = c; e.busy = b; e.done = d; e.ready = r;
    sb.push_back(e);
  endtask

  // Advance one edge and compare against the oldest scoreboard entry.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".count"}, 8'(count), 8'(e.count));
      chk({e.tag, ".busy"},  8'(busy),  8'(e.busy));
      chk({e.tag, ".done"},  8'(done),  8'(e.done));
      chk({e.tag, ".ready"}, 8'(ld.load_ready), 8'(e.ready));
    end
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; abort = 1'b0;
    ld.load_valid = 1'b0; ld.load_value = '0; ld.auto_reload = 1'b0;

    // Reset held two cycles
    expect_out("rst0", 4'd0, 0, 0, 1); step();
    expect_out("rst1", 4'd0, 0, 0, 1); step();
    rst = 1'b0;
    expect_out("idle", 4'd0, 0, 0, 1); step();

    // One-shot of 5: 5,4,3,2,1 busy, then 0 with done
    ld.load_valid = 1'b1; ld.load_value = 4'd5; ld.auto_reload = 1'b0;
    expect_out("os5_load", 4'd5, 1, 0, 0); step();
    ld.load_valid = 1'b0;
    for (int unsigned v = 4; v >= 1; v--) begin
      expect_out("os5_run", W'(v), 1, 0, 0); step();
    end
    expect_out("os5_term", 4'd0, 0, 1, 1); step();
    expect_out("os5_after", 4'd0, 0, 0, 1); step();

    // One-shot of 15 (largest value): done at t0+16
    ld.load_valid = 1'b1; ld.load_value = 4'd15;
    expect_out("os15_load", 4'd15, 1, 0, 0); step();
    ld.load_valid = 1'b0;
    for (int unsigned v = 14; v >= 1; v--) begin
      expect_out("os15_run", W'(v), 1, 0, 0); step();
    end
    expect_out("os15_term", 4'd0, 0, 1, 1); step();

    // Auto-reload of 3, then abort
    ld.load_valid = 1'b1; ld.load_value = 4'd3; ld.auto_reload = 1'b1;
    expect_out("ar_load", 4'd3, 1, 0, 0); step();
    ld.load_valid = 1'b0; ld.auto_reload = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      expect_out("ar_2", 4'd2, 1, 0, 0); step();
      expect_out("ar_1", 4'd1, 1, 0, 0); step();
      expect_out("ar_reload", 4'd3, 1, 1, 0); step();
    end
    expect_out("ar_2b", 4'd2, 1, 0, 0); step();
    abort = 1'b1;
    expect_out("ar_abort", 4'd0, 0, 0, 0); step();
    abort = 1'b0;
    expect_out("ar_idle", 4'd0, 0, 0, 1); step();

    // Pause two cycles while count=2: done at t0+7
    ld.load_valid = 1'b1; ld.load_value = 4'd4;
    expect_out("ps_load", 4'd4, 1, 0, 0); step();
    ld.load_valid = 1'b0;
    expect_out("ps_3", 4'd3, 1, 0, 0); step();
    expect_out("ps_2", 4'd2, 1, 0, 0); step();
    pause = 1'b1;
    expect_out("ps_hold0", 4'd2, 1, 0, 0); step();
    expect_out("ps_hold1", 4'd2, 1, 0, 0); step();
    pause = 1'b0;
    expect_out("ps_1", 4'd1, 1, 0, 0); step();
    expect_out("ps_term", 4'd0, 0, 1, 1); step();

    // Pause in IDLE has no effect; zero load pulses done without busy
    pause = 1'b1;
    ld.load_valid = 1'b1; ld.load_value = 4'd0;
    expect_out("zero_load", 4'd0, 0, 1, 1); step();
    ld.load_valid = 1'b0; pause = 1'b0;
    expect_out("zero_after", 4'd0, 0, 0, 1); step();

    // load_valid held with a different value through RUN is ignored
    ld.load_valid = 1'b1; ld.load_value = 4'd3;
    expect_out("hold_load", 4'd3, 1, 0, 0); step();
    ld.load_value = 4'd9;
    expect_out("hold_2", 4'd2, 1, 0, 0); step();
    expect_out("hold_1", 4'd1, 1, 0, 0); step();
    expect_out("hold_term", 4'd0, 0, 1, 1); step();
    ld.load_valid = 1'b0;
    expect_out("hold_idle", 4'd0, 0, 0, 1); step();

    // abort together with load_valid in IDLE blocks the load
    abort = 1'b1; ld.load_valid = 1'b1; ld.load_value = 4'd7;
    #1;
    chk("abort_ready_comb", 8'(ld.load_ready), 8'd0);
    expect_out("abort_noload", 4'd0, 0, 0, 0); step();
    abort = 1'b0; ld.load_valid = 1'b0;
    expect_out("abort_idle", 4'd0, 0, 0, 1); step();

    // Reset at count=2 during a one-shot of 6
    ld.load_valid = 1'b1; ld.load_value = 4'd6;
    expect_out("mr_load", 4'd6, 1, 0, 0); step();
    ld.load_valid = 1'b0;
    for (int unsigned v = 5; v >= 2; v--) begin
      expect_out("mr_run", W'(v), 1, 0, 0); step();
    end
    rst = 1'b1;
    expect_out("mr_rst", 4'd0, 0, 0, 1); step();
    rst = 1'b0;
    expect_out("mr_idle", 4'd0, 0, 0, 1); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
